// File: rtl/simon_tone_gen.sv
// simon_tone_gen: square-wave note player for the Simon game.
// Each accepted request plays one note (or the long low lose tone), then holds
// AUDIO low for a silent gap and pulses DONE. BUSY covers both tone and gap.
module simon_tone_gen #(
    parameter int unsigned FREQ_IN = 50_000_000,
    parameter int unsigned DUR_MS  = 300,
    parameter int unsigned GAP_MS  = 50,
    parameter int unsigned LOSE_MS = 1500
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [1:0] NOTE,
    input  logic       LOSE_REQ,
    output logic       AUDIO,
    output logic       BUSY,
    output logic       DONE
);

    // Half-periods in clock cycles for the four notes and the lose tone
    localparam int unsigned HALF_0    = FREQ_IN / (2 * 415);
    localparam int unsigned HALF_1    = FREQ_IN / (2 * 310);
    localparam int unsigned HALF_2    = FREQ_IN / (2 * 252);
    localparam int unsigned HALF_3    = FREQ_IN / (2 * 209);
    localparam int unsigned HALF_LOSE = FREQ_IN / (2 * 42);

    // ms * Hz can exceed 32 bits at real clock rates, so work in 64 bits
    localparam longint unsigned DUR_W  = 64'(DUR_MS) * 64'(FREQ_IN) / 64'd1000;
    localparam longint unsigned GAP_W  = 64'(GAP_MS) * 64'(FREQ_IN) / 64'd1000;
    localparam longint unsigned LOSE_W = 64'(LOSE_MS) * 64'(FREQ_IN) / 64'd1000;
    localparam int unsigned DUR_CYC  = 32'(DUR_W);
    localparam int unsigned GAP_CYC  = 32'(GAP_W);
    localparam int unsigned LOSE_CYC = 32'(LOSE_W);

    // Counter width covers the largest length or half-period so nothing wraps
    localparam int unsigned MAX_A = (DUR_CYC > GAP_CYC) ? DUR_CYC : GAP_CYC;
    localparam int unsigned MAX_B = (MAX_A > LOSE_CYC) ? MAX_A : LOSE_CYC;
    localparam int unsigned MAX_V = (MAX_B > HALF_LOSE) ? MAX_B : HALF_LOSE;
    localparam int unsigned CW    = $clog2(MAX_V + 1);

    typedef enum logic [1:0] {StIdle, StTone, StGap} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   dur_cnt_q, dur_cnt_d;
    logic [CW-1:0]   half_cnt_q, half_cnt_d;
    logic [CW-1:0]   half_len_q, half_len_d;
    logic [CW-1:0]   tone_len_q, tone_len_d;
    logic            audio_q, audio_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [CW-1:0]   note_half;

    // Decode the requested note into its half-period
    always_comb begin
        note_half = CW'(HALF_0);
        unique case (NOTE)
            2'd0: note_half = CW'(HALF_0);
            2'd1: note_half = CW'(HALF_1);
            2'd2: note_half = CW'(HALF_2);
            2'd3: note_half = CW'(HALF_3);
            default: note_half = CW'(HALF_0);
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        dur_cnt_d  = dur_cnt_q;
        half_cnt_d = half_cnt_q;
        half_len_d = half_len_q;
        tone_len_d = tone_len_q;
        audio_d    = audio_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            StIdle: begin
                audio_d = 1'b0;
                busy_d  = 1'b0;
                // Lose request wins; period and length are frozen here
                if (LOSE_REQ || START) begin
                    state_d    = StTone;
                    busy_d     = 1'b1;
                    audio_d    = 1'b1;
                    dur_cnt_d  = '0;
                    half_cnt_d = '0;
                    half_len_d = LOSE_REQ ? CW'(HALF_LOSE) : note_half;
                    tone_len_d = LOSE_REQ ? CW'(LOSE_CYC) : CW'(DUR_CYC);
                end
            end
            StTone: begin
                if (dur_cnt_q == tone_len_q - CW'(1)) begin
                    state_d    = StGap;
                    dur_cnt_d  = '0;
                    half_cnt_d = '0;
                    audio_d    = 1'b0;
                end else begin
                    dur_cnt_d = dur_cnt_q + CW'(1);
                    if (half_cnt_q == half_len_q - CW'(1)) begin
                        half_cnt_d = '0;
                        audio_d    = ~audio_q;
                    end else begin
                        half_cnt_d = half_cnt_q + CW'(1);
                    end
                end
            end
            StGap: begin
                audio_d = 1'b0;
                if (dur_cnt_q == CW'(GAP_CYC - 1)) begin
                    state_d   = StIdle;
                    dur_cnt_d = '0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end else begin
                    dur_cnt_d = dur_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                audio_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any tone without a DONE
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            dur_cnt_q  <= '0;
            half_cnt_q <= '0;
            half_len_q <= '0;
            tone_len_q <= '0;
            audio_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dur_cnt_q  <= dur_cnt_d;
            half_cnt_q <= half_cnt_d;
            half_len_q <= half_len_d;
            tone_len_q <= tone_len_d;
            audio_q    <= audio_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign AUDIO = audio_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;

endmodule

// File: tb/tb_simon_tone_gen.sv
// Bench for simon_tone_gen: a driver issues randomized requests and pushes the
// expected note episode into a scoreboard; a monitor replays each episode.
module tb_simon_tone_gen;

    localparam int FREQ    = 100_000;
    localparam int DUR_MS  = 10;
    localparam int GAP_MS  = 2;
    localparam int LOSE_MS = 20;
    localparam int DUR     = DUR_MS * FREQ / 1000;
    localparam int GAP     = GAP_MS * FREQ / 1000;
    localparam int LOSE    = LOSE_MS * FREQ / 1000;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic       LOSE_REQ = 1'b0;
    logic [1:0] NOTE = 2'd0;
    logic       AUDIO, BUSY, DONE;

    typedef struct {
        int edge_n;
        int half;
        int len;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   last_end = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   n_pushed = 0;
    int   n_done = 0;
    bit   in_ep = 1'b0;

    simon_tone_gen #(
        .FREQ_IN (FREQ),
        .DUR_MS  (DUR_MS),
        .GAP_MS  (GAP_MS),
        .LOSE_MS (LOSE_MS)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .NOTE     (NOTE),
        .LOSE_REQ (LOSE_REQ),
        .AUDIO    (AUDIO),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint exp_v);
        n_total++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    endtask

    function automatic int half_of(input int idx);
        int hz;
        case (idx)
            0: hz = 415;
            1: hz = 310;
            2: hz = 252;
            3: hz = 209;
            default: hz = 42;
        endcase
        return FREQ / (2 * hz);
    endfunction

    // Square wave starts high and flips every half cycles; silent in the gap
    function automatic bit exp_audio(input int jj, input exp_t e);
        if (jj >= e.len) return 1'b0;
        return ((jj / e.half) % 2) == 0;
    endfunction

    // One cycle of stimulus; the model accepts only when its own note has ended
    task automatic drive(input bit s, input logic [1:0] n, input bit l);
        int   e;
        exp_t x;
        START    = s;
        NOTE     = n;
        LOSE_REQ = l;
        e = cyc + 1;
        if (e > last_end && (s || l)) begin
            x.edge_n = e;
            x.half   = l ? half_of(4) : half_of(int'(n));
            x.len    = l ? LOSE : DUR;
            sb.push_back(x);
            n_pushed++;
            last_end = e + x.len + GAP;
        end
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 2'($urandom), 1'b0);
    endtask

    // Monitor: consumes one scoreboard entry per BUSY period
    initial begin
        exp_t cur;
        int   j = 0;
        int   wave_err = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                in_ep = 1'b0;
                sb.delete();
            end else if (in_ep) begin
                if (BUSY) begin
                    if (AUDIO !== exp_audio(j, cur)) wave_err++;
                    j++;
                end else begin
                    check("busy_len", j, cur.len + GAP);
                    check("wave_errors", wave_err, 0);
                    check("done_at_end", DONE, 1);
                    if (DONE) n_done++;
                    in_ep = 1'b0;
                end
            end else if (BUSY) begin
                check("busy_has_request", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    cur = sb.pop_front();
                    check("start_edge", cyc, cur.edge_n);
                    in_ep    = 1'b1;
                    wave_err = (AUDIO !== exp_audio(0, cur)) ? 1 : 0;
                    j        = 1;
                end
            end else begin
                check("idle_quiet", {AUDIO, DONE}, 0);
            end
        end
    end

    initial begin
        int t;
        // Reset values
        repeat (3) @(negedge CLK);
        check("rst_audio", AUDIO, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        #2 RST = 1'b0;
        @(negedge CLK);

        // Idle
        idle(50);
        // Single note 0
        drive(1'b1, 2'd0, 1'b0);
        idle(1250);
        // Notes 1..3 with NOTE scrambled mid-tone
        for (int n = 1; n <= 3; n++) begin
            drive(1'b1, 2'(n), 1'b0);
            idle(1250);
        end
        // START and LOSE_REQ together, plus a START during BUSY that is ignored
        drive(1'b1, 2'($urandom), 1'b1);
        idle(600);
        drive(1'b1, 2'($urandom), 1'b0);
        idle(1700);
        // START held high: back-to-back notes
        for (int i = 0; i < 3 * (DUR + GAP + 1) + 5; i++) drive(1'b1, 2'($urandom), 1'b0);
        idle(1300);
        // Sparse random requests
        for (int i = 0; i < 4000; i++)
            drive($urandom_range(0, 299) == 0, 2'($urandom), $urandom_range(0, 999) == 0);
        idle(2300);

        // Asynchronous reset 500 cycles into a tone
        drive(1'b1, 2'd0, 1'b0);
        idle(499);
        START = 1'b0;
        #2 RST = 1'b1;
        #1;
        check("abort_audio", AUDIO, 0);
        check("abort_busy", BUSY, 0);
        check("abort_done", DONE, 0);
        @(negedge CLK);
        #2 RST = 1'b0;
        n_pushed--;  // aborted episode never reaches DONE
        last_end = 0;
        @(negedge CLK);
        idle(100);
        drive(1'b1, 2'd0, 1'b0);
        idle(1250);

        // Drain with a bound
        t = 0;
        while ((BUSY || in_ep || sb.size() != 0) && t < 5000) begin
            @(negedge CLK);
            t++;
        end
        repeat (3) @(negedge CLK);
        check("drain_in_time", t < 5000, 1);
        check("sb_empty", sb.size(), 0);
        check("done_count", n_done, n_pushed);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/simon_tone_gen.md
# simon_tone_gen

Square-wave tone player for the Simon game, sitting downstream of `controller` alongside the lamp decode. Each accepted request plays one note for a fixed duration, followed by a silent gap, then reports completion; a dedicated low "lose" tone is also available. `AUDIO` drives the buzzer pin directly, and the controller uses `BUSY`/`DONE` to pace sequence playback.

## Interface
Parameters:
- `FREQ_IN`, 50_000_000 — `CLK` frequency in Hz.
- `DUR_MS`, 300 — note duration in ms.
- `GAP_MS`, 50 — silent gap after each note or lose tone, in ms.
- `LOSE_MS`, 1500 — lose-tone duration in ms.

Ports:
- `CLK` in 1 — system clock, single clock domain.
- `RST` in 1 — reset, asynchronous, active-high.
- `START` in 1 — request to play `NOTE`, sampled on each rising edge.
- `NOTE` in 2 — note select: 0 = 415 Hz, 1 = 310 Hz, 2 = 252 Hz, 3 = 209 Hz.
- `LOSE_REQ` in 1 — request to play the 42 Hz lose tone.
- `AUDIO` out 1 — square-wave output, registered.
- `BUSY` out 1 — high while in TONE or GAP.
- `DONE` out 1 — one-cycle pulse when the gap ends.

## Operation
Derived constants, all integer division with truncation:
- `HALF[n] = FREQ_IN / (2*f_n)`, for each of the 5 tones.
- `DUR = DUR_MS*FREQ_IN/1000`, `GAP = GAP_MS*FREQ_IN/1000`, `LOSE = LOSE_MS*FREQ_IN/1000`.
- Counters are sized to hold the largest of these values; no wrap is permitted.

State machine:
- States are IDLE, TONE, GAP.
- **IDLE**
  - `LOSE_REQ`=1 → TONE with the lose half-period and length `LOSE`.
  - Otherwise `START`=1 → TONE with `HALF[NOTE]` and length `DUR`.
  - `LOSE_REQ` has priority when both are high.
  - The half-period and length are latched at acceptance; later changes to `NOTE` have no effect.
- **TONE**
  - Duration counter counts 0..len-1; at len-1 → GAP.
  - Half-period counter counts 0..half-1; at half-1 it toggles `AUDIO` and restarts from 0.
- **GAP**
  - `AUDIO`=0; counter counts 0..`GAP`-1; at `GAP`-1 → IDLE with `DONE`=1.
- `START` and `LOSE_REQ` are ignored outside IDLE. There is no queuing; the requester waits for `BUSY`=0.
- A request arriving in the same cycle `DONE` is high is accepted, because the state is already IDLE.
- `RST` mid-tone aborts immediately to IDLE with all outputs 0. No `DONE` is issued.

## Timing
- Reset values: `AUDIO`=0, `BUSY`=0, `DONE`=0, state IDLE, all counters 0.
- Request sampled high in IDLE at edge k:
  - After edge k: state TONE, `BUSY`=1, `AUDIO`=1, both counters 0.
  - First `AUDIO` toggle (to 0) at edge k+half.
  - After that, `AUDIO` toggles every half cycles.
- TONE occupies exactly len cycles. At edge k+len: state GAP, `AUDIO`=0. The half-period phase at that point does not matter.
- At edge k+len+`GAP`: state IDLE, `BUSY`=0, `DONE`=1 for exactly one cycle.
- Back-to-back playback: a request held high in the `DONE` cycle restarts at edge k+len+`GAP`+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Bench configuration: `FREQ_IN`=100_000, `DUR_MS`=10, `GAP_MS`=2, `LOSE_MS`=20. This gives `DUR`=1000, `GAP`=200, `LOSE`=2000, and `HALF` = 120 / 161 / 198 / 239, lose 1190.

1. Reset, then idle for 50 cycles → `AUDIO`=0, `BUSY`=0, `DONE`=0 throughout.
2. `START` for one cycle with `NOTE`=0 → `AUDIO` high for 120 cycles, then toggles every 120 cycles. `BUSY` high for 1200 cycles. `AUDIO`=0 for the final 200 of those cycles. One `DONE` pulse at cycle 1200.
3. For each `NOTE` in 1..3, `START` with `NOTE` changed mid-tone → the measured half-period is 161 / 198 / 239 and is unaffected by the `NOTE` change.
4. `START` and `LOSE_REQ` asserted in the same cycle → half-period 1190, `BUSY` for 2200 cycles. A `START` pulse during `BUSY` is ignored (exactly one `DONE`).
5. `START` held continuously high → consecutive notes with exactly 1 `DONE` cycle between `BUSY` periods, and a `DONE` pulse every 1201 cycles.
6. Assert `RST` asynchronously at cycle 500 of a tone → `AUDIO`, `BUSY`, `DONE` go to 0 immediately. No `DONE` follows. A fresh `START` after release behaves as in scenario 2.
